tft_sync_timing_gen: RTL and testbench
======================================

// Module: tft_sync_timing_gen
// PURPOSE
//   Generates TFT panel raster timing: HS, VS, DE and pixel coordinates from a
//   single pixel clock. Also drives the 2-bit vs_int_out bus feeding the VS
//   interrupt PIO, whose edge detector captures 1->0 transitions:
//   bit0 = VS start, bit1 = end of the active frame (framebuffer-swap window).
// PARAMETERS
//   H_ACTIVE  480  visible pixels per line
//   H_FP      2    horizontal front porch, clocks
//   H_SYNC    41   HS pulse width, clocks
//   H_BP      2    horizontal back porch, clocks
//   V_ACTIVE  272  visible lines per frame
//   V_FP      2    vertical front porch, lines
//   V_SYNC    10   VS pulse width, lines
//   V_BP      2    vertical back porch, lines
//   CW        11   width of h/v counters and pix_x/pix_y
// PORTS
//   clk          in   1   pixel clock, single clock domain
//   reset        in   1   asynchronous, active-high reset
//   enable       in   1   1 = run raster; 0 = hold idle (synchronous)
//   tft_hs       out  1   horizontal sync, active low
//   tft_vs       out  1   vertical sync, active low
//   tft_de       out  1   data enable, high on visible pixels
//   pix_x        out  CW  visible column, 0..H_ACTIVE-1 (0 when de=0)
//   pix_y        out  CW  visible row, 0..V_ACTIVE-1 (0 when de=0)
//   vs_int_out   out  2   [0] = tft_vs level, [1] = in_active_frame
//   frame_cnt    out  16  completed-frame counter
// BEHAVIOUR
// - Reset and polarity: one clock domain. reset is asynchronous and active-high.
// - Reset values: tft_hs=1, tft_vs=1, tft_de=0, pix_x=0, pix_y=0,
//   vs_int_out=2'b01, frame_cnt=0. Internal h_cnt=0, v_cnt=0.
// - Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
// - Horizontal counter: h_cnt runs 0..H_TOTAL-1, then wraps to 0.
// - Vertical counter: v_cnt advances by 1 only on the h_cnt wrap. It runs
//   0..V_TOTAL-1, then wraps to 0.
// - Line and frame order, per counter: SYNC [0,H_SYNC), BP, ACTIVE
//   [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), FP. Vertical uses the same order in
//   lines.
// - Output latency: all outputs are registered decodes of (h_cnt, v_cnt), so
//   each output lags its counter state by exactly 1 clock.
//   - tft_hs = 0 while h in SYNC.
//   - tft_vs = 0 while v in SYNC, for whole lines.
//   - tft_de = h in ACTIVE and v in ACTIVE.
//   - pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP) when de, else 0.
//   - pix_x/pix_y are aligned with tft_de.
// - vs_int_out[0] equals tft_vs, same cycle. Its 1->0 edge occurs once per
//   frame, at VS start.
// - vs_int_out[1] = 1 for every clock of lines with v in ACTIVE, including
//   h blanking. It falls exactly once per frame: the clock after the last
//   clock of the last active line.
// - frame_cnt increments by 1 on the v_cnt wrap (V_TOTAL-1 -> 0 with the
//   h wrap). It wraps 0xFFFF -> 0 silently.
// - enable=0 (synchronous):
//   - On the next edge, h_cnt/v_cnt clear to 0 and all outputs take their
//     reset values; frame_cnt holds.
//   - While enable=0, nothing changes.
//   - After enable returns to 1, counting starts at h=0,v=0, so the raster
//     begins in SYNC and vs_int_out[0] falls after 1 clock.
//   - Dropping enable mid-frame neither completes the frame nor bumps
//     frame_cnt.
// - Reset mid-frame: outputs go to reset values immediately (async). After
//   release, behaviour is identical to enable rising.
// - Sanity: all porch/sync parameters must be >=1, and H_TOTAL, V_TOTAL must be
//   < 2**CW. Simulation-only assertion; no RTL handling.
// TESTING (bench params H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1 -> H_TOTAL=8;
//          V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1 -> V_TOTAL=6; frame = 48 clocks)
// 1. Release reset, enable=1: tft_hs low for clocks 1-2 of every 8;
//    tft_vs low for clocks 1-8; frame_cnt=1 at clock 49.
// 2. DE/coords: de high 4 clocks per line on 3 lines (12/frame). First de
//    is at clock 2*8+3+1=20 with pix_x=0,pix_y=0; the last de has pix_x=3,pix_y=2.
// 3. vs_int_out: bit0 falls at clocks 1, 49, 97 (one per frame); bit1 high
//    clocks 17-40 and falls at clock 41; never two falls in one frame.
// 4. enable=0 at clock 25 (mid active): next edge returns all outputs to
//    reset values and frame_cnt is unchanged. Re-enable: tft_vs falls 1 clock later.
// 5. Assert reset at clock 30 for 3 clocks: outputs idle asynchronously
//    within the clock; after release the sequence matches scenario 1.
// 6. Preload-free wrap: run 65536 frames with fast params; frame_cnt
//    returns to 0 and vs_int_out[0] falls count equals frames run.

Source files
------------

// File: rtl/tft_sync_timing_gen.sv
// TFT raster timing generator: HS/VS/DE, visible pixel coordinates, the VS-interrupt
// edge bus and a completed-frame counter, all registered one clock behind (h_cnt, v_cnt).

module tft_sync_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          tft_hs,
    output logic          tft_vs,
    output logic          tft_de,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [1:0]    vs_int_out,
    output logic [15:0]   frame_cnt
);

    localparam logic [CW-1:0] H_LAST      = CW'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG   = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] V_ACT_BEG   = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    logic [CW-1:0] h_cnt_nxt_s;
    logic [CW-1:0] v_cnt_nxt_s;
    logic          h_last_s;
    logic          v_last_s;
    logic          frame_end_s;

    logic          hs_s;
    logic          vs_s;
    logic          h_act_s;
    logic          v_act_s;
    logic          de_s;
    logic [CW-1:0] pix_x_s;
    logic [CW-1:0] pix_y_s;

    logic          hs_r;
    logic          vs_r;
    logic          de_r;
    logic [CW-1:0] pix_x_r;
    logic [CW-1:0] pix_y_r;
    logic          act_frame_r;
    logic          frame_wrap_r;
    logic [15:0]   frame_cnt_r;

    // Next raster position: h wraps every line, v steps only on the h wrap.
    always_comb begin
        h_last_s    = (h_cnt_r == H_LAST);
        v_last_s    = (v_cnt_r == V_LAST);
        frame_end_s = h_last_s && v_last_s;
        h_cnt_nxt_s = h_cnt_r + CNT_ONE;
        v_cnt_nxt_s = v_cnt_r;
        if (h_last_s) begin
            h_cnt_nxt_s = CNT_ZERO;
            if (v_last_s) begin
                v_cnt_nxt_s = CNT_ZERO;
            end else begin
                v_cnt_nxt_s = v_cnt_r + CNT_ONE;
            end
        end else begin
            v_cnt_nxt_s = v_cnt_r;
        end
    end

    // Combinational decode of the current raster position.
    always_comb begin
        hs_s    = (h_cnt_r >= H_SYNC_END);
        vs_s    = (v_cnt_r >= V_SYNC_END);
        h_act_s = (h_cnt_r >= H_ACT_BEG) && (h_cnt_r < H_ACT_END);
        v_act_s = (v_cnt_r >= V_ACT_BEG) && (v_cnt_r < V_ACT_END);
        de_s    = h_act_s && v_act_s;
        pix_x_s = CNT_ZERO;
        pix_y_s = CNT_ZERO;
        if (de_s) begin
            pix_x_s = h_cnt_r - H_ACT_BEG;
            pix_y_s = v_cnt_r - V_ACT_BEG;
        end else begin
            pix_x_s = CNT_ZERO;
            pix_y_s = CNT_ZERO;
        end
    end

    // Raster counters; a low enable parks them at the start of SYNC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
        end else if (!enable) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
        end else begin
            h_cnt_r <= h_cnt_nxt_s;
            v_cnt_r <= v_cnt_nxt_s;
        end
    end

    // Output registers. frame_wrap_r delays the frame count so it moves with the
    // first decode of the new frame rather than with the counter wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_r         <= 1'b1;
            vs_r         <= 1'b1;
            de_r         <= 1'b0;
            pix_x_r      <= CNT_ZERO;
            pix_y_r      <= CNT_ZERO;
            act_frame_r  <= 1'b0;
            frame_wrap_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else if (!enable) begin
            hs_r         <= 1'b1;
            vs_r         <= 1'b1;
            de_r         <= 1'b0;
            pix_x_r      <= CNT_ZERO;
            pix_y_r      <= CNT_ZERO;
            act_frame_r  <= 1'b0;
            frame_wrap_r <= 1'b0;
            frame_cnt_r  <= frame_cnt_r;
        end else begin
            hs_r         <= hs_s;
            vs_r         <= vs_s;
            de_r         <= de_s;
            pix_x_r      <= pix_x_s;
            pix_y_r      <= pix_y_s;
            act_frame_r  <= v_act_s;
            frame_wrap_r <= frame_end_s;
            frame_cnt_r  <= frame_cnt_r + {15'd0, frame_wrap_r};
        end
    end

    assign tft_hs     = hs_r;
    assign tft_vs     = vs_r;
    assign tft_de     = de_r;
    assign pix_x      = pix_x_r;
    assign pix_y      = pix_y_r;
    assign vs_int_out = {act_frame_r, vs_r};
    assign frame_cnt  = frame_cnt_r;

    tft_sync_timing_gen_chk #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_chk (
        .clk   (clk),
        .reset (reset)
    );

endmodule

// Simulation-only parameter sanity checker; carries no logic.
module tft_sync_timing_gen_chk #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int CW       = 11
) (
    input logic clk,
    input logic reset
);

    localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam bit PARAMS_OK = (H_FP >= 1) && (H_SYNC >= 1) && (H_BP >= 1) &&
                               (V_FP >= 1) && (V_SYNC >= 1) && (V_BP >= 1) &&
                               (H_TOTAL < (2 ** CW)) && (V_TOTAL < (2 ** CW));

    // Timing parameters must describe a non-degenerate raster that fits CW bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (PARAMS_OK) else $error("tft_sync_timing_gen: illegal timing parameters");
        end
    end

endmodule

// File: tb/tb_tft_sync_timing_gen.sv
// Self-checking bench for tft_sync_timing_gen: a raster-position model compared every
// clock, directed timing checks, random enable/reset activity and a minimal-timing instance.

module tb_tft_sync_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        tft_hs, tft_vs, tft_de;
    logic [10:0] pix_x, pix_y;
    logic [1:0]  vs_int_out;
    logic [15:0] frame_cnt;

    logic        reset2 = 1'b1;
    logic        hs2, vs2, de2;
    logic [10:0] px2, py2;
    logic [1:0]  vi2;
    logic [15:0] fc2;

    int tests = 0;
    int fails = 0;

    int s = 0;
    int prev_s = -1;
    int fc = 0;
    int n_clk = 0;
    int falls0 = 0;
    int falls1 = 0;
    int de_cnt = 0;
    logic [1:0] prev_vi = 2'b01;
    logic [63:0] exp_vec = 64'd0;

    always #5 clk = ~clk;

    tft_sync_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CW(11)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .tft_hs(tft_hs), .tft_vs(tft_vs), .tft_de(tft_de),
        .pix_x(pix_x), .pix_y(pix_y), .vs_int_out(vs_int_out), .frame_cnt(frame_cnt)
    );

    tft_sync_timing_gen #(
        .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(11)
    ) dut_fast (
        .clk(clk), .reset(reset2), .enable(1'b1),
        .tft_hs(hs2), .tft_vs(vs2), .tft_de(de2),
        .pix_x(px2), .pix_y(py2), .vs_int_out(vi2), .frame_cnt(fc2)
    );

    function automatic logic [63:0] pack(input logic hs, input logic vs, input logic de,
                                         input logic [10:0] x, input logic [10:0] y,
                                         input logic [1:0] vi, input logic [15:0] f);
        return {21'd0, hs, vs, de, x, y, vi, f};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (clk %0d)", tag, obs, exp, n_clk);
        end
    endtask

    function automatic logic [63:0] idle_vec(input int f);
        return pack(1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 2'b01, 16'(f));
    endfunction

    task automatic model_reset();
        s = 0;
        prev_s = -1;
        fc = 0;
        exp_vec = idle_vec(0);
    endtask

    // Reference: raster position s counts pixel clocks within the frame.
    task automatic model_edge();
        int h, v;
        bit hact, vact, de;
        if (reset) begin
            model_reset();
        end else if (!enable) begin
            s = 0;
            prev_s = -1;
            exp_vec = idle_vec(fc);
        end else begin
            h = s % HT;
            v = s / HT;
            hact = (h >= HS + HB) && (h < HS + HB + HA);
            vact = (v >= VS + VB) && (v < VS + VB + VA);
            de = hact && vact;
            if (s == 0 && prev_s == FT - 1) fc = (fc + 1) % 65536;
            exp_vec = pack(h >= HS, v >= VS, de,
                           de ? 11'(h - HS - HB) : 11'd0,
                           de ? 11'(v - VS - VB) : 11'd0,
                           {vact, v >= VS}, 16'(fc));
            prev_s = s;
            s = (s + 1) % FT;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        n_clk++;
        check("cycle", pack(tft_hs, tft_vs, tft_de, pix_x, pix_y, vs_int_out, frame_cnt), exp_vec);
        if (prev_vi[0] && !vs_int_out[0]) falls0++;
        if (prev_vi[1] && !vs_int_out[1]) falls1++;
        if (tft_de) de_cnt++;
        prev_vi = vs_int_out;
    endtask

    task automatic restart();
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
        enable = 1'b1;
        n_clk = 0;
        falls0 = 0;
        falls1 = 0;
        de_cnt = 0;
    endtask

    initial begin
        int ff0, fd;
        logic [1:0] pv2;

        // Reset state
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check("reset_state", pack(tft_hs, tft_vs, tft_de, pix_x, pix_y, vs_int_out, frame_cnt), idle_vec(0));

        // Scenario 1-3: free run from reset release
        reset = 1'b0;
        n_clk = 0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (n == 1)  check("hsvs_clk1", {62'd0, tft_hs, tft_vs}, 64'd0);
            if (n == 3)  check("hs_clk3", {63'd0, tft_hs}, 64'd1);
            if (n == 8)  check("vs_clk8", {63'd0, tft_vs}, 64'd0);
            if (n == 9)  check("vs_clk9", {63'd0, tft_vs}, 64'd1);
            if (n == 20) check("first_de", {41'd0, tft_de, pix_x, pix_y}, {41'd0, 1'b1, 11'd0, 11'd0});
            if (n == 39) check("last_de", {41'd0, tft_de, pix_x, pix_y}, {41'd0, 1'b1, 11'd3, 11'd2});
            if (n == 40) check("act_clk40", {63'd0, vs_int_out[1]}, 64'd1);
            if (n == 41) check("act_fall41", {63'd0, vs_int_out[1]}, 64'd0);
            if (n == 48) check("de_per_frame", 64'(de_cnt), 64'd12);
            if (n == 48) check("fc_clk48", {48'd0, frame_cnt}, 64'd0);
            if (n == 49) check("fc_clk49", {48'd0, frame_cnt}, 64'd1);
        end
        check("vs_falls_100", 64'(falls0), 64'd3);
        check("act_falls_100", 64'(falls1), 64'd2);

        // Scenario 4: drop enable at frame clock 25
        for (int n = 0; n < 20; n++) step();
        enable = 1'b0;
        step();
        check("en_off_idle", pack(tft_hs, tft_vs, tft_de, pix_x, pix_y, vs_int_out, frame_cnt), idle_vec(2));
        for (int n = 0; n < 3; n++) step();
        check("en_off_hold", pack(tft_hs, tft_vs, tft_de, pix_x, pix_y, vs_int_out, frame_cnt), idle_vec(2));
        enable = 1'b1;
        n_clk = 0;
        step();
        check("reen_vs", {62'd0, tft_vs, vs_int_out[0]}, 64'd0);

        // Scenario 5: asynchronous reset at clock 30
        for (int n = 0; n < 28; n++) step();
        #2 reset = 1'b1;
        #1 model_reset();
        check("async_reset", pack(tft_hs, tft_vs, tft_de, pix_x, pix_y, vs_int_out, frame_cnt), idle_vec(0));
        for (int n = 0; n < 3; n++) step();
        @(negedge clk);
        reset = 1'b0;
        n_clk = 0;
        for (int n = 1; n <= 49; n++) begin
            step();
            if (n == 1)  check("rst_vs_clk1", {63'd0, tft_vs}, 64'd0);
            if (n == 20) check("rst_first_de", {41'd0, tft_de, pix_x, pix_y}, {41'd0, 1'b1, 11'd0, 11'd0});
            if (n == 49) check("rst_fc_clk49", {48'd0, frame_cnt}, 64'd1);
        end

        // Random enable drops and reset pulses against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199, 0) == 0) begin
                enable = 1'b0;
                for (int k = 0; k < int'($urandom_range(5, 1)); k++) step();
                enable = 1'b1;
            end else if ($urandom_range(499, 0) == 0) begin
                reset = 1'b1;
                for (int k = 0; k < int'($urandom_range(3, 1)); k++) step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        // Long uninterrupted run: one VS fall and one active-frame fall per frame
        restart();
        for (int n = 0; n < 100 * FT; n++) step();
        check("long_vs_falls", 64'(falls0), 64'd100);
        check("long_act_falls", 64'(falls1), 64'd100);
        check("long_fc", {48'd0, frame_cnt}, 64'd99);

        // Minimal-timing instance: 16-clock frames
        reset2 = 1'b0;
        ff0 = 0;
        fd = 0;
        pv2 = 2'b01;
        for (int n = 0; n < 16000; n++) begin
            @(negedge clk);
            if (pv2[0] && !vi2[0]) ff0++;
            if (de2) fd++;
            pv2 = vi2;
        end
        check("fast_vs_falls", 64'(ff0), 64'd1000);
        check("fast_de_count", 64'(fd), 64'd1000);
        check("fast_fc", {48'd0, fc2}, 64'd999);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
